// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MRUN = 2'd1,
    DRUN = 2'd2,
    DONE = 2'd3
  } state_e;

  // Engine iteration counts; the watchdog limit has to exceed both.
  localparam int MULT_ITERS      = 16;
  localparam int DIV_ITERS       = 32;
  localparam int DEFAULT_TIMEOUT = 40;

endpackage

// File: rtl/multdiv_watchdog.sv
// Clearable, enabled up-counter that saturates at TIMEOUT and never wraps.
// tc is high on the enabled cycle whose increment lands on TIMEOUT.
module multdiv_watchdog #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != TERM)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && (count_q == LAST);

endmodule

// File: rtl/multdiv_sequencer.sv
// Captures a mult/div request, starts one engine, collects its result and pulses data_resultRDY once.
// resultRDY follows the sampled engine ready by one cycle; requests are never stalled, a new one aborts the current op.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             mult_start,
  input  logic             mult_ready,
  input  logic [WIDTH-1:0] mult_result,
  input  logic             mult_overflow,
  output logic             div_start,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_result,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             mult_start_q, mult_start_d;
  logic             div_start_q, div_start_d;

  logic req_any, req_bad, div_zero, run, m_hit, d_hit, wd_tc, wd_fire;

  assign req_any  = ctrl_MULT | ctrl_DIV;
  assign req_bad  = ctrl_MULT & ctrl_DIV;
  assign div_zero = ctrl_DIV & ~ctrl_MULT & (data_operandB == '0);
  assign run      = (state_q == MRUN) || (state_q == DRUN);

  // Ready seen while start is still high belongs to the previous operation.
  assign m_hit   = (state_q == MRUN) && !mult_start_q && mult_ready;
  assign d_hit   = (state_q == DRUN) && !div_start_q && div_ready;
  assign wd_fire = run && wd_tc && !m_hit && !d_hit;

  multdiv_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .clr   (req_any),
    .en    (run),
    .tc    (wd_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      exc_q        <= 1'b0;
      rdy_q        <= 1'b0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      exc_q        <= exc_d;
      rdy_q        <= rdy_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
    end
  end

  // A request from any state wins over whatever the current state would do.
  always_comb begin
    state_d = state_q;
    if (req_any) begin
      if (req_bad || div_zero) begin
        state_d = DONE;
      end else if (ctrl_MULT) begin
        state_d = MRUN;
      end else begin
        state_d = DRUN;
      end
    end else begin
      case (state_q)
        MRUN, DRUN: if (m_hit || d_hit || wd_fire) state_d = DONE;
        DONE:       state_d = IDLE;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    exc_d        = exc_q;
    rdy_d        = (state_d == DONE);
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    if (req_any) begin
      op_a_d       = data_operandA;
      op_b_d       = data_operandB;
      result_d     = '0;
      exc_d        = req_bad | div_zero;
      mult_start_d = (state_d == MRUN);
      div_start_d  = (state_d == DRUN);
    end else if (m_hit) begin
      result_d = mult_result;
      exc_d    = mult_overflow;
    end else if (d_hit) begin
      result_d = div_result;
      exc_d    = 1'b0;
    end else if (wd_fire) begin
      result_d = '0;
      exc_d    = 1'b1;
    end
  end

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign mult_start     = mult_start_q;
  assign div_start      = div_start_q;
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: behavioural engine stubs, a result scoreboard and a vector table.
module tb_multdiv_sequencer;

  localparam int TO = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] op_a, op_b;
  logic        mult_start, div_start;
  logic        mult_ready    = 1'b0;
  logic [31:0] mult_result   = '0;
  logic        mult_overflow = 1'b0;
  logic        div_ready     = 1'b0;
  logic [31:0] div_result    = '0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  multdiv_sequencer #(.WIDTH(32), .TIMEOUT(TO), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .op_a           (op_a),
    .op_b           (op_b),
    .mult_start     (mult_start),
    .mult_ready     (mult_ready),
    .mult_result    (mult_result),
    .mult_overflow  (mult_overflow),
    .div_start      (div_start),
    .div_ready      (div_ready),
    .div_result     (div_result),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Engine stubs: ready rises lat edges after the start pulse; lat 0 keeps ready high throughout.
  int m_lat = 17, d_lat = 4, m_cnt = 0, d_cnt = 0;

  always @(posedge clock) begin : mult_stub
    logic signed [63:0] p;
    if (mult_start) begin
      p = 64'($signed(op_a)) * 64'($signed(op_b));
      mult_result   <= p[31:0];
      mult_overflow <= (p != {{32{p[31]}}, p[31:0]});
      mult_ready    <= (m_lat == 0);
      m_cnt         <= (m_lat == 0) ? 0 : 1;
    end else if (m_cnt != 0) begin
      if (m_cnt + 1 == m_lat) begin
        mult_ready <= 1'b1;
        m_cnt      <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(posedge clock) begin : div_stub
    if (div_start) begin
      div_result <= (op_b != 0) ? 32'($signed(op_a) / $signed(op_b)) : 32'd0;
      div_ready  <= (d_lat == 0);
      d_cnt      <= (d_lat == 0) ? 0 : 1;
    end else if (d_cnt != 0) begin
      if (d_cnt + 1 == d_lat) begin
        div_ready <= 1'b1;
        d_cnt     <= 0;
      end else begin
        d_cnt <= d_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [31:0] res;
    bit          exc;
    int          lat;
    int          req_cyc;
  } exp_t;

  typedef struct {
    bit          m;
    bit          d;
    logic [31:0] a;
    logic [31:0] b;
    int          mlat;
    int          dlat;
    logic [31:0] res;
    bit          exc;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vq[$];
  int   errors = 0, checks = 0, cyc = 0, n_mstart = 0, n_dstart = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One cycle: advance to the falling edge and run the monitor on what the DUT shows.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    cyc++;
    if (mult_start) n_mstart++;
    if (div_start)  n_dstart++;
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: resultRDY with nothing pending, result=0x%0h", data_result);
      end else begin
        e = sb.pop_front();
        chk("rdy_result", data_result, e.res);
        chk("rdy_exception", 32'(data_exception), 32'(e.exc));
        chk("rdy_latency", 32'(cyc - e.req_cyc), 32'(e.lat));
      end
    end
  endtask

  task automatic send(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input bit exc, input int lat, input bit flush);
    exp_t e;
    if (flush) sb.delete();
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    e.res     = res;
    e.exc     = exc;
    e.lat     = lat;
    e.req_cyc = cyc + 1;
    sb.push_back(e);
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: %0d results pending after %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  initial begin
    vec_t v;
    //                m  d  a        b        mlat  dlat res          exc lat
    vq.push_back('{1, 0, 7,       -3,      17,   0,   -21,         0,  18});
    vq.push_back('{0, 1, 100,     0,       0,    0,   0,           1,  0});
    vq.push_back('{1, 0, 32'h10000, 32'h10000, 5, 0,  0,           1,  6});
    vq.push_back('{1, 0, 12345,   -1,      0,    0,   -12345,      0,  2});
    vq.push_back('{0, 1, 100,     7,       0,    33,  14,          0,  34});
    vq.push_back('{0, 1, -100,    7,       0,    4,   -14,         0,  5});
    vq.push_back('{1, 1, 5,       5,       0,    0,   0,           1,  0});
    vq.push_back('{1, 0, 9,       9,       1000, 0,   0,           1,  TO});
    vq.push_back('{0, 1, 81,      9,       0,    39,  9,           0,  TO});
    vq.push_back('{1, 0, 2,       3,       40,   0,   0,           1,  TO});
    vq.push_back('{1, 0, -4,      -5,      2,    0,   20,          0,  3});
    vq.push_back('{0, 1, 7,       -7,      0,    3,   -1,          0,  4});

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #1;
    chk("reset_op_a", op_a, 32'd0);
    chk("reset_op_b", op_b, 32'd0);
    chk("reset_result", data_result, 32'd0);
    chk("reset_flags", {28'd0, data_exception, data_resultRDY, mult_start, div_start}, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      m_lat = v.mlat;
      d_lat = v.dlat;
      n_mstart = 0;
      n_dstart = 0;
      send(v.m, v.d, v.a, v.b, v.res, v.exc, v.lat, 1'b1);
      wait_done(3 * TO);
      repeat (2) tick();
      chk("hold_result", data_result, v.res);
      chk("hold_exception", 32'(data_exception), 32'(v.exc));
      chk("mult_start_cycles", 32'(n_mstart), 32'(v.m && !v.d));
      chk("div_start_cycles", 32'(n_dstart), 32'(v.d && !v.m && v.b != 0));
    end

    // Abort: divide restarted as a multiply five cycles in; late div_ready must be ignored.
    m_lat = 4;
    d_lat = 8;
    n_mstart = 0;
    n_dstart = 0;
    send(0, 1, 100, 7, 14, 0, 9, 1'b1);
    repeat (4) tick();
    send(1, 0, 6, 5, 30, 0, 5, 1'b1);
    wait_done(3 * TO);
    repeat (15) tick();
    chk("abort_mult_starts", 32'(n_mstart), 32'd1);
    chk("abort_div_starts", 32'(n_dstart), 32'd1);
    chk("abort_hold_result", data_result, 32'd30);

    // Request on the edge that ends DONE is taken.
    m_lat = 3;
    n_mstart = 0;
    n_dstart = 0;
    send(0, 1, 100, 0, 0, 1, 0, 1'b1);
    send(1, 0, 3, 4, 12, 0, 4, 1'b0);
    wait_done(3 * TO);
    chk("back2back_mult_starts", 32'(n_mstart), 32'd1);
    chk("back2back_div_starts", 32'(n_dstart), 32'd0);

    // Asynchronous reset in the middle of a divide.
    d_lat = 20;
    send(0, 1, 50, 5, 10, 0, 21, 1'b1);
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    chk("midrun_rst_op_a", op_a, 32'd0);
    chk("midrun_rst_op_b", op_b, 32'd0);
    chk("midrun_rst_result", data_result, 32'd0);
    chk("midrun_rst_flags", {28'd0, data_exception, data_resultRDY, mult_start, div_start}, 32'd0);
    tick();
    reset = 1'b0;
    sb.delete();
    tick();
    d_lat = 5;
    n_dstart = 0;
    send(0, 1, 9, 3, 3, 0, 6, 1'b1);
    wait_done(3 * TO);
    repeat (25) tick();
    chk("after_rst_div_starts", 32'(n_dstart), 32'd1);
    chk("after_rst_result", data_result, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
